// File: rtl/mac_feeder.sv
// mac_feeder: sequencer that feeds the 8-bit MAC processing element.
// A job first loads KERNEL_TAPS weight bytes into a local register file.
// It then streams IFM bytes. Each IFM byte is paired with the weight for
// its tap and registered to the PE, together with window first/last markers.
// Optional feature macro: MAC_FEEDER_WEIGHT_REUSE_EN. When it is defined, the
// reuse_w port is added and a job may skip LOAD_W and use the stored weights.
module mac_feeder #(
    parameter int KERNEL_TAPS = 9,
    parameter int TAP_W       = $clog2(KERNEL_TAPS)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] num_windows,
`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
    input  logic        reuse_w,
`endif
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [7:0]  w_data,
    input  logic        ifm_valid,
    output logic        ifm_ready,
    input  logic [7:0]  ifm_data,
    output logic [7:0]  pe_ifm,
    output logic [7:0]  pe_weight,
    output logic        pe_valid,
    output logic        pe_first,
    output logic        pe_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_TAPS - 1);

    state_t            state_reg, state_next;
    logic [TAP_W-1:0]  tap_reg, tap_next;
    logic [15:0]       win_cnt_reg, win_cnt_next;
    logic [15:0]       num_win_reg, num_win_next;
    logic [7:0]        wreg [KERNEL_TAPS];
    logic              w_we;
    logic              ifm_acc;
    logic              done_next;

`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
    logic              w_loaded_reg;
`endif

    // Ready and busy come straight from the registered state, so they only
    // move on clock edges.
    assign w_ready   = (state_reg == LOAD_W);
    assign ifm_ready = (state_reg == STREAM);
    assign busy      = (state_reg != IDLE);

    // State, tap counter, window counter and job length registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            tap_reg     <= '0;
            win_cnt_reg <= '0;
            num_win_reg <= '0;
        end else begin
            state_reg   <= state_next;
            tap_reg     <= tap_next;
            win_cnt_reg <= win_cnt_next;
            num_win_reg <= num_win_next;
        end
    end

    // Next-state logic: job accept, weight load sequencing and IFM streaming.
    always_comb begin
        state_next   = state_reg;
        tap_next     = tap_reg;
        win_cnt_next = win_cnt_reg;
        num_win_next = num_win_reg;
        w_we         = 1'b0;
        ifm_acc      = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                // A zero-length job is dropped without leaving IDLE.
                if (start && (num_windows != 16'd0)) begin
                    num_win_next = num_windows;
                    tap_next     = '0;
                    win_cnt_next = '0;
                    state_next   = LOAD_W;
`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
                    if (reuse_w && w_loaded_reg) begin
                        state_next = STREAM;
                    end
`endif
                end
            end
            LOAD_W: begin
                if (w_valid) begin
                    w_we = 1'b1;
                    if (tap_reg == LAST_TAP) begin
                        tap_next   = '0;
                        state_next = STREAM;
                    end else begin
                        tap_next = tap_reg + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (ifm_valid) begin
                    ifm_acc = 1'b1;
                    if (tap_reg == LAST_TAP) begin
                        tap_next     = '0;
                        win_cnt_next = win_cnt_reg + 16'd1;
                        // The last tap of the final window ends the job.
                        if (win_cnt_reg == (num_win_reg - 16'd1)) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        tap_next = tap_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Weight register file. Reset clears it, so weights never survive a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                wreg[i] <= 8'd0;
            end
        end else if (w_we) begin
            wreg[tap_reg] <= w_data;
        end
    end

`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
    // Remembers that a full weight set has been loaded since the last reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_loaded_reg <= 1'b0;
        end else if (w_we && (tap_reg == LAST_TAP)) begin
            w_loaded_reg <= 1'b1;
        end
    end
`endif

    // PE operand register. Operands hold their value between beats, while
    // the strobes go low whenever there is no handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_ifm    <= 8'd0;
            pe_weight <= 8'd0;
            pe_valid  <= 1'b0;
            pe_first  <= 1'b0;
            pe_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            pe_valid <= ifm_acc;
            pe_first <= ifm_acc && (tap_reg == '0);
            pe_last  <= ifm_acc && (tap_reg == LAST_TAP);
            done     <= done_next;
            if (ifm_acc) begin
                pe_ifm    <= ifm_data;
                pe_weight <= wreg[tap_reg];
            end
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: scoreboard bench for mac_feeder (KERNEL_TAPS=9).
// Expected PE pairs are pushed when an IFM handshake is seen and popped one
// cycle later, when the DUT must present them.
// Also exercises MAC_FEEDER_WEIGHT_REUSE_EN when that macro is defined.
`timescale 1ns/1ps
module tb_mac_feeder;

    localparam int K = 9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_windows = 16'd0;
`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
    logic        reuse_w = 1'b0;
`endif
    logic        w_valid = 1'b0;
    logic [7:0]  w_data = 8'd0;
    logic        ifm_valid = 1'b0;
    logic [7:0]  ifm_data = 8'd0;
    logic        w_ready, ifm_ready;
    logic [7:0]  pe_ifm, pe_weight;
    logic        pe_valid, pe_first, pe_last, busy, done;

    mac_feeder #(.KERNEL_TAPS(K)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .num_windows(num_windows),
`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
        .reuse_w    (reuse_w),
`endif
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .ifm_valid  (ifm_valid),
        .ifm_ready  (ifm_ready),
        .ifm_data   (ifm_data),
        .pe_ifm     (pe_ifm),
        .pe_weight  (pe_weight),
        .pe_valid   (pe_valid),
        .pe_first   (pe_first),
        .pe_last    (pe_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ifm;
        logic [7:0] w;
        logic       first;
        logic       last;
        logic       done;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         beats = 0;
    int         done_cnt = 0;
    logic       pending = 1'b0;
    logic [7:0] model_w [K];
    int         m_tap = 0;
    int         m_win = 0;
    int         m_wtap = 0;
    int         m_nwin = 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and reference model, evaluated on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            pending = 1'b0;
            sb_q.delete();
            m_tap  = 0;
            m_win  = 0;
            m_wtap = 0;
            for (int i = 0; i < K; i++) model_w[i] = 8'd0;
        end else begin
            if (pending) begin
                e = sb_q.pop_front();
                beats++;
                $display("beat %0d ifm=%0d w=%0d first=%0b last=%0b done=%0b",
                         beats, pe_ifm, pe_weight, pe_first, pe_last, done);
                check_val("pe_valid", 32'(pe_valid), 32'd1);
                check_val("pe_ifm", 32'(pe_ifm), 32'(e.ifm));
                check_val("pe_weight", 32'(pe_weight), 32'(e.w));
                check_val("pe_first", 32'(pe_first), 32'(e.first));
                check_val("pe_last", 32'(pe_last), 32'(e.last));
                check_val("done_beat", 32'(done), 32'(e.done));
            end else begin
                check_val("idle_pe_valid", 32'(pe_valid), 32'd0);
                check_val("idle_done", 32'(done), 32'd0);
            end
            if (done) done_cnt++;
            // A legal start is accepted only while idle.
            if (start && !busy && (num_windows != 16'd0)) begin
                m_nwin = int'(num_windows);
                m_tap  = 0;
                m_win  = 0;
                m_wtap = 0;
            end
            if (w_valid && w_ready) begin
                model_w[m_wtap] = w_data;
                m_wtap = (m_wtap == K - 1) ? 0 : m_wtap + 1;
            end
            pending = ifm_valid && ifm_ready;
            if (pending) begin
                e.ifm   = ifm_data;
                e.w     = model_w[m_tap];
                e.first = (m_tap == 0);
                e.last  = (m_tap == K - 1);
                e.done  = (m_tap == K - 1) && (m_win == m_nwin - 1);
                sb_q.push_back(e);
                if (m_tap == K - 1) begin
                    m_tap = 0;
                    m_win++;
                end else begin
                    m_tap++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input bit reuse);
        start = 1'b1;
        num_windows = n[15:0];
`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
        reuse_w = reuse;
`else
        if (reuse) $display("note: reuse requested without weight reuse build");
`endif
        tick();
        start = 1'b0;
`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
        reuse_w = 1'b0;
`endif
    endtask

    task automatic load_weights(input int base, input bit bubble);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < K && guard < 2000) begin
            w_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
            w_data  = 8'(base + i);
            acc = w_valid && w_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        w_valid = 1'b0;
        if (i < K) check_val("w_timeout", 32'(i), 32'(K));
    endtask

    task automatic stream_ifm(input int count, input int base, input bit bubble, input int inject_at);
        int   j = 0;
        int   guard = 0;
        logic acc;
        while (j < count && guard < 4000) begin
            ifm_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
            ifm_data  = 8'(base + j);
            start     = (guard == inject_at);
            if (guard == inject_at) num_windows = 16'd5;
            acc = ifm_valid && ifm_ready;
            tick();
            if (acc) j++;
            guard++;
        end
        ifm_valid = 1'b0;
        start     = 1'b0;
        if (j < count) check_val("ifm_timeout", 32'(j), 32'(count));
    endtask

    initial begin
        int b0, d0;

        // Reset state, observed while reset is held.
        #2;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_w_ready", 32'(w_ready), 32'd0);
        check_val("rst_ifm_ready", 32'(ifm_ready), 32'd0);
        check_val("rst_pe_valid", 32'(pe_valid), 32'd0);
        check_val("rst_pe_ifm", 32'(pe_ifm), 32'd0);
        check_val("rst_pe_weight", 32'(pe_weight), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Basic job: 2 windows, weights 1..9, IFM 10..27.
        b0 = beats; d0 = done_cnt;
        do_start(2, 1'b0);
        check_val("basic_busy", 32'(busy), 32'd1);
        check_val("basic_w_ready", 32'(w_ready), 32'd1);
        load_weights(1, 1'b0);
        check_val("basic_ifm_ready", 32'(ifm_ready), 32'd1);
        check_val("basic_w_ready_off", 32'(w_ready), 32'd0);
        stream_ifm(18, 10, 1'b0, -1);
        check_val("basic_done", 32'(done), 32'd1);
        check_val("basic_busy_off", 32'(busy), 32'd0);
        tick();
        check_val("basic_beats", 32'(beats - b0), 32'd18);
        check_val("basic_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Zero-window start is ignored.
        d0 = done_cnt;
        do_start(0, 1'b0);
        tick();
        check_val("zero_busy", 32'(busy), 32'd0);
        check_val("zero_w_ready", 32'(w_ready), 32'd0);
        check_val("zero_done_cnt", 32'(done_cnt - d0), 32'd0);

        // Random bubbles, plus a start pulse during STREAM that must be ignored.
        b0 = beats; d0 = done_cnt;
        do_start(2, 1'b0);
        load_weights(1, 1'b1);
        stream_ifm(18, 10, 1'b1, 6);
        check_val("bubble_done", 32'(done), 32'd1);
        tick();
        check_val("bubble_beats", 32'(beats - b0), 32'd18);
        check_val("bubble_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_val("bubble_busy", 32'(busy), 32'd0);

        // Back-to-back jobs: the next start lands in the done cycle.
        b0 = beats;
        do_start(1, 1'b0);
        load_weights(30, 1'b0);
        stream_ifm(9, 50, 1'b0, -1);
        check_val("b2b_done", 32'(done), 32'd1);
        check_val("b2b_busy_low", 32'(busy), 32'd0);
        do_start(1, 1'b0);
        check_val("b2b_busy", 32'(busy), 32'd1);
        check_val("b2b_w_ready", 32'(w_ready), 32'd1);
        load_weights(40, 1'b0);
        stream_ifm(9, 60, 1'b0, -1);
        tick();
        check_val("b2b_beats", 32'(beats - b0), 32'd18);

        // Reset after window 1 tap 4, then a fresh job.
        do_start(2, 1'b0);
        load_weights(70, 1'b0);
        stream_ifm(14, 80, 1'b0, -1);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_pe_valid", 32'(pe_valid), 32'd0);
        check_val("mid_rst_pe_first", 32'(pe_first), 32'd0);
        check_val("mid_rst_pe_ifm", 32'(pe_ifm), 32'd0);
        check_val("mid_rst_pe_weight", 32'(pe_weight), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_ifm_ready", 32'(ifm_ready), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        b0 = beats;
        do_start(1, 1'b0);
        load_weights(90, 1'b0);
        stream_ifm(9, 100, 1'b0, -1);
        tick();
        check_val("post_rst_beats", 32'(beats - b0), 32'd9);

`ifdef MAC_FEEDER_WEIGHT_REUSE_EN
        // Weight reuse: the second job skips LOAD_W and uses weights 1..9.
        do_start(1, 1'b0);
        load_weights(1, 1'b0);
        stream_ifm(9, 10, 1'b0, -1);
        tick();
        b0 = beats;
        do_start(1, 1'b1);
        check_val("reuse_w_ready", 32'(w_ready), 32'd0);
        check_val("reuse_ifm_ready", 32'(ifm_ready), 32'd1);
        stream_ifm(9, 110, 1'b0, -1);
        tick();
        check_val("reuse_beats", 32'(beats - b0), 32'd9);
        // Reuse straight after reset has no weights, so it loads them.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        do_start(1, 1'b1);
        check_val("reuse_rst_w_ready", 32'(w_ready), 32'd1);
        load_weights(5, 1'b0);
        stream_ifm(9, 120, 1'b0, -1);
        tick();
`endif

        tick();
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
